// File: rtl/mult_div_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: op codes, FSM states, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_div_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = cnt_width(MD_WIDTH);

endpackage

// File: rtl/mult_div_sign_fix.sv
// Signed operand/result conditioning for mult_div_unit; compiled only with MULT_DIV_SIGNED_EN.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
`ifdef MULT_DIV_SIGNED_EN
module mult_div_sign_fix
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic                 a_neg,
    output logic                 b_neg,
    input  logic                 sign_a,
    input  logic                 sign_b,
    input  logic [2*WIDTH-1:0]   prod_raw,
    input  logic [WIDTH-1:0]     quot_raw,
    input  logic [WIDTH-1:0]     rem_raw,
    output logic [2*WIDTH-1:0]   prod_fix,
    output logic [WIDTH-1:0]     quot_fix,
    output logic [WIDTH-1:0]     rem_fix
);

    logic res_neg;

    assign a_neg = signed_op & a[WIDTH-1];
    assign b_neg = signed_op & b[WIDTH-1];
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    assign a_mag = a_neg ? ('0 - a) : a;
    assign b_mag = b_neg ? ('0 - b) : b;

    assign res_neg  = sign_a ^ sign_b;
    assign prod_fix = res_neg ? ('0 - prod_raw) : prod_raw;
    assign quot_fix = res_neg ? ('0 - quot_raw) : quot_raw;
    // Remainder follows the dividend's sign.
    assign rem_fix  = sign_a  ? ('0 - rem_raw)  : rem_raw;

endmodule
`endif

// File: rtl/mult_div_unit.sv
// MIPS mult/multu/div/divu: shift-add multiply, restoring divide, results in HI/LO; MULT_DIV_SIGNED_EN enables signed ops.
// Latency: done in cycle WIDTH+1 after start is accepted; divide by zero completes in cycle 1.
// Backpressure: busy high from accept through done; start outside IDLE is dropped, not queued.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 is_div_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic [WIDTH-1:0]     mag_a_q;
    logic [WIDTH-1:0]     mag_b_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     quot_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   prod_nxt;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       rem_nxt;
    logic [WIDTH-1:0]     quot_nxt;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic                 unused_ok;

`ifdef MULT_DIV_SIGNED_EN
    mult_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_op (op[0]),
        .a         (a),
        .b         (b),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .sign_a    (sign_a_q),
        .sign_b    (sign_b_q),
        .prod_raw  (prod_nxt),
        .quot_raw  (quot_nxt),
        .rem_raw   (rem_nxt[WIDTH-1:0]),
        .prod_fix  (prod_fix),
        .quot_fix  (quot_fix),
        .rem_fix   (rem_fix)
    );
    assign unused_ok = ^{rem_q[WIDTH], rem_nxt[WIDTH]};
`else
    assign a_mag    = a;
    assign b_mag    = b;
    assign a_neg    = 1'b0;
    assign b_neg    = 1'b0;
    assign prod_fix = prod_nxt;
    assign quot_fix = quot_nxt;
    assign rem_fix  = rem_nxt[WIDTH-1:0];
    assign unused_ok = ^{op[0], sign_a_q, sign_b_q, rem_q[WIDTH], rem_nxt[WIDTH]};
`endif

    // One iteration of each algorithm; only the one matching is_div_q is committed.
    always_comb begin
        add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
        prod_nxt = {add_sum, prod_q[WIDTH-1:1]};
        shifted  = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
        rem_nxt  = shifted;
        quot_nxt = {quot_q[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, mag_b_q}) begin
            rem_nxt  = shifted - {1'b0, mag_b_q};
            quot_nxt = {quot_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div_q    <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            prod_q      <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        sign_a_q <= a_neg;
                        sign_b_q <= b_neg;
                        mag_a_q  <= a_mag;
                        mag_b_q  <= b_mag;
                        cnt      <= '0;
                        prod_q   <= {{WIDTH{1'b0}}, b_mag};
                        rem_q    <= '0;
                        quot_q   <= a_mag;
                        if (op[1] && (b == '0)) begin
                            state       <= DONE;
                            hi          <= a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div_q) begin
                        rem_q  <= rem_nxt;
                        quot_q <= quot_nxt;
                    end else begin
                        prod_q <= prod_nxt;
                    end
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= DONE;
                        if (is_div_q) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    div_by_zero <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: HI/LO results, done/busy timing, ignored start, reset abort.
// Expected values are hand-computed; signed-only vectors switch on MULT_DIV_SIGNED_EN.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives start there, returns at the negedge of the cycle after done.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input int exp_cyc, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz);
        int cyc;
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy1"}, 64'(busy), 64'd1);
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_cyc"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        @(negedge clk);
        check({tag, "_idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int ndone;
        int first;

        rst_n = 1'b0; start = 1'b0; op = OP_MULTU; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`ifdef MULT_DIV_SIGNED_EN
        do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
`else
        do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 33, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
`endif
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
`ifdef MULT_DIV_SIGNED_EN
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);
`else
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        do_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0, 1'b0);
`endif
        do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);

        // Start pulsed mid-RUN must be dropped; HI/LO hold while a/b move.
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
        ndone = 0; first = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
            if (c == 10) begin start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd0; end
            if (c == 11) start = 1'b0;
            if (c == 20) check("ign_hold", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
            if (c == 33) check("ign_result", {hi, lo}, {32'd0, 32'd12});
        end
        check("ign_ndone", 64'(ndone), 64'd1);
        check("ign_cyc", 64'(first), 64'd33);

        // Mid-RUN reset aborts with no done.
        start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("rst_mid_nodone", 64'(ndone), 64'd0);

        // Reset beats a simultaneous start.
        rst_n = 1'b0; start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        check("rst_vs_start", 64'({busy, done}), 64'd0);
        @(negedge clk);
        check("rst_vs_start2", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle MIPS multiply/divide unit consuming the ALU operand pair: `a` comes from register-file read port 1, and `b` is the ALU-source mux output (register or sign-extended immediate). It executes mult/multu/div/divu with a start/busy/done handshake and holds the results in architectural HI/LO registers read by mfhi/mflo. It sits beside the single-cycle ALU in the execute stage; the control unit stalls the PC while `busy` is high.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low; sampled on the clk rising edge.
- start  in  1  request; accepted only in IDLE.
- op  in  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor (ALU-source mux output).
- busy  out  1  high from the accepting edge through the DONE cycle.
- done  out  1  one-cycle pulse; HI and LO are valid in that cycle.
- div_by_zero  out  1  valid with done; set for div/divu with b == 0.
- hi  out  WIDTH  HI register: product upper half or remainder.
- lo  out  WIDTH  LO register: product lower half or quotient.

## Operation
- States:
  - IDLE: accepts start.
  - RUN: iterates WIDTH steps.
  - DONE: for one cycle, asserts done.
- Transitions:
  - IDLE to RUN on start.
  - IDLE to DONE directly on start with divide and b == 0.
  - RUN to DONE when the step counter reaches WIDTH-1.
  - DONE to IDLE unconditionally.
- On accept, latch op, |a| and |b| (absolute values for signed ops, raw values for unsigned ops), and the operand signs. Clear the step counter.
- Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- Divide: restoring division, one quotient bit per cycle; the remainder register is WIDTH+1 bits.
- Signed sign fix-up, applied when entering DONE:
  - Product is negated (2*WIDTH two's complement) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- div 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000 and HI = 0. This falls out of unsigned magnitudes and needs no special case.
- Divide by zero: HI = a, LO = all ones, div_by_zero = 1.
- HI and LO change only on the edge entering DONE. They hold otherwise, including while `a` and `b` change during RUN.
- A start asserted in RUN or DONE is ignored, not queued.

## Timing
- Start sampled high in cycle 0 (IDLE):
  - busy = 1 from cycle 1.
  - done = 1 in cycle WIDTH+1 (cycle 33 for WIDTH = 32).
  - busy = 0 and the unit is back in IDLE in cycle WIDTH+2.
- Divide by zero: done and div_by_zero in cycle 1; IDLE in cycle 2.
- Earliest back-to-back start: the cycle right after done.
- Reset, with rst_n low at an edge:
  - next state is IDLE;
  - busy = 0, done = 0, div_by_zero = 0;
  - hi = 0, lo = 0;
  - counter and internal registers cleared.
  - A mid-RUN reset aborts the operation, and no done is produced.
- rst_n low and start high on the same edge: reset wins.

## Configuration
- MULT_DIV_SIGNED_EN defined: op[0] selects signed mult/div; the sign fix-up logic is present.
- MULT_DIV_SIGNED_EN undefined: op[0] is ignored and every operation is unsigned. The abs/negate logic is removed.

## Structure
- Package mult_div_pkg:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state enum (IDLE, RUN, DONE);
  - the counter width constant, $clog2(WIDTH).
- One sub-module: mult_div_sign_fix, combinational. It computes operand absolute values on accept and applies result negation on completion. It is only instantiated under MULT_DIV_SIGNED_EN.

## Test plan
- multu a = 0xFFFFFFFF, b = 0xFFFFFFFF: done in cycle 33, HI = 0xFFFFFFFE, LO = 0x00000001, busy low in cycle 34.
- mult a = 0xFFFFFFFD (-3), b = 5: HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. With MULT_DIV_SIGNED_EN undefined: HI = 0x00000004, LO = 0xFFFFFFF1.
- divu 100 / 7: LO = 14, HI = 2. div 0xFFFFFFF9 (-7) / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- divu 5 / 0: done and div_by_zero in cycle 1, HI = 5, LO = 0xFFFFFFFF.
- Start pulsed in cycle 10 of a running multu 3 * 4: ignored; single done in cycle 33, LO = 12.
- rst_n low in cycle 10 of an operation: cycle 11 has busy = 0, HI = LO = 0, and no done within the next 40 cycles.
